// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared glyph table and decode function for the seven-segment display driver
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low gfedcba. Entry n is the glyph for nibble n.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h58, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg7_glyph_f(input logic [3:0] nibble);
        return GLYPH_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_glyph.sv
// rtl/seg7_glyph.sv - combinational nibble to active-low segment decoder
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = seg7_glyph_f(nibble_i);

endmodule

// File: rtl/seg7_multi_disp.sv
// rtl/seg7_multi_disp.sv - multi-digit hex display driver with static and scanned outputs,
// leading-zero suppression, decimal points and per-digit blinking
module seg7_multi_disp
    import seg7_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int BLINK_DIV = 25000000,
    parameter int SCAN_DIV  = 50000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [4*DIGITS-1:0]   data_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic [DIGITS-1:0]     blink_en_i,
    input  logic                  load_i,
    input  logic                  lz_en_i,
    output logic [7*DIGITS-1:0]   hex_o,
    output logic [DIGITS-1:0]     hex_dp_o,
    output logic [7:0]            seg_o,
    output logic [DIGITS-1:0]     dig_o
);

    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("seg7_multi_disp: DIGITS must be in 1..8");
    end
    if (BLINK_DIV < 1) begin : g_bad_blink
        $error("seg7_multi_disp: BLINK_DIV must be >= 1");
    end
    if (SCAN_DIV < 1) begin : g_bad_scan
        $error("seg7_multi_disp: SCAN_DIV must be >= 1");
    end

    logic [4*DIGITS-1:0] data_q, data_d;
    logic [DIGITS-1:0]   dp_q, dp_d, blink_q, blink_d;
    logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
    logic                phase_q, phase_d;
    logic [SW-1:0]       scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [7*DIGITS-1:0] hex_q, hex_d;
    logic [DIGITS-1:0]   hex_dp_q, hex_dp_d;
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   dig_q, dig_d;
    logic [7*DIGITS-1:0] glyph_w;
    logic [DIGITS-1:0]   sup;
    logic                lead;
    logic                off;

    for (genvar g = 0; g < DIGITS; g++) begin : g_glyph
        seg7_glyph u_glyph (
            .nibble_i (data_q[4*g +: 4]),
            .seg_o    (glyph_w[7*g +: 7])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q      <= '0;
            dp_q        <= '0;
            blink_q     <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            hex_q       <= '1;
            hex_dp_q    <= '1;
            seg_q       <= 8'hFF;
            dig_q       <= '1;
        end else begin
            data_q      <= data_d;
            dp_q        <= dp_d;
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            hex_q       <= hex_d;
            hex_dp_q    <= hex_dp_d;
            seg_q       <= seg_d;
            dig_q       <= dig_d;
        end
    end

    always_comb begin
        data_d  = load_i ? data_i     : data_q;
        dp_d    = load_i ? dp_i       : dp_q;
        blink_d = load_i ? blink_en_i : blink_q;

        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end

        scan_cnt_d = scan_cnt_q + 1'b1;
        idx_d      = idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Leading zeros blank from the top digit down; digit 0 always shows.
    always_comb begin
        sup  = '0;
        lead = lz_en_i;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lead   = lead && (data_q[4*i +: 4] == 4'h0);
            sup[i] = lead;
        end
    end

    always_comb begin
        hex_d    = '1;
        hex_dp_d = '1;
        off      = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            off               = phase_q & blink_q[i];
            hex_d[7*i +: 7]   = (off || sup[i]) ? SEG_BLANK : glyph_w[7*i +: 7];
            hex_dp_d[i]       = ~(dp_q[i] & ~off);
        end
    end

    // Scan bus samples the registered static outputs, adding one more stage.
    always_comb begin
        seg_d = 8'hFF;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                seg_d = {hex_dp_q[i], hex_q[7*i +: 7]};
            end
        end
        dig_d = ~(DIGITS'(1) << idx_q);
    end

    assign hex_o    = hex_q;
    assign hex_dp_o = hex_dp_q;
    assign seg_o    = seg_q;
    assign dig_o    = dig_q;

endmodule

// File: tb/tb_seg7_multi_disp.sv
// tb/tb_seg7_multi_disp.sv - directed self-checking bench for seg7_multi_disp
module tb_seg7_multi_disp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blink_en;
    logic        load;
    logic        lz_en;
    logic [27:0] hex;
    logic [3:0]  hex_dp;
    logic [7:0]  seg;
    logic [3:0]  dig;
    logic [6:0]  hex1;
    logic        hex_dp1;
    logic [7:0]  seg1;
    logic        dig1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_multi_disp #(.DIGITS(4), .BLINK_DIV(4), .SCAN_DIV(3)) u_dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .data_i     (data),
        .dp_i       (dp),
        .blink_en_i (blink_en),
        .load_i     (load),
        .lz_en_i    (lz_en),
        .hex_o      (hex),
        .hex_dp_o   (hex_dp),
        .seg_o      (seg),
        .dig_o      (dig)
    );

    seg7_multi_disp #(.DIGITS(1), .BLINK_DIV(4), .SCAN_DIV(3)) u_dut1 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .data_i     (data[3:0]),
        .dp_i       (1'b0),
        .blink_en_i (1'b0),
        .load_i     (load),
        .lz_en_i    (lz_en),
        .hex_o      (hex1),
        .hex_dp_o   (hex_dp1),
        .seg_o      (seg1),
        .dig_o      (dig1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] glyph_ref(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h58;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [27:0] hex_ref(input logic [15:0] w);
        logic [27:0] r;
        for (int i = 0; i < 4; i++) r[7*i +: 7] = glyph_ref(w[4*i +: 4]);
        return r;
    endfunction

    task automatic load_word(input logic [15:0] w, input logic [3:0] d);
        data = w;
        dp   = d;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
    endtask

    logic [15:0] sweep [4]  = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
    logic [15:0] track [8]  = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
                                16'h0F0F, 16'hA5A5, 16'hFFFF, 16'h0000};

    initial begin
        rst_n = 1'b0; data = '0; dp = '0; blink_en = '0; load = 1'b0; lz_en = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_hex", hex, 32'h0FFF_FFFF);
        check("rst_hex_dp", hex_dp, 32'hF);
        check("rst_seg", seg, 32'hFF);
        check("rst_dig", dig, 32'hF);
        check("rst_hex1", hex1, 32'h7F);
        rst_n = 1'b1;

        load_word(16'h1234, 4'b0000);
        check("load_1234", hex, {4'h0, 7'h79, 7'h24, 7'h30, 7'h19});

        load_word(16'h0123, 4'b0101);
        check("sweep_0123_hand", hex, {4'h0, 7'h40, 7'h79, 7'h24, 7'h30});
        check("dp_0101", hex_dp, 32'hA);
        for (int i = 0; i < 4; i++) begin
            load_word(sweep[i], 4'b0000);
            check($sformatf("sweep_%h", sweep[i]), hex, hex_ref(sweep[i]));
        end
        check("dp_none", hex_dp, 32'hF);

        lz_en = 1'b1;
        load_word(16'h0040, 4'b1000);
        check("lz_0040", hex, {4'h0, 7'h7F, 7'h7F, 7'h19, 7'h40});
        check("lz_dp_kept", hex_dp, 32'h7);
        lz_en = 1'b0;
        @(negedge clk);
        check("lz_off_edge", hex, {4'h0, 7'h40, 7'h40, 7'h19, 7'h40});
        lz_en = 1'b1;
        @(negedge clk);
        check("lz_on_edge", hex, {4'h0, 7'h7F, 7'h7F, 7'h19, 7'h40});
        load_word(16'h0000, 4'b0000);
        check("lz_zero", hex, {4'h0, 7'h7F, 7'h7F, 7'h7F, 7'h40});
        lz_en = 1'b0;

        data = track[0];
        load = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i >= 2) check($sformatf("track_%0d", i - 2), hex, hex_ref(track[i - 2]));
            if (i < 8) data = track[i];
        end

        // Asynchronous reset mid-cycle, then blink from a known phase.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_hex", hex, 32'h0FFF_FFFF);
        check("arst_seg", seg, 32'hFF);
        check("arst_dig", dig, 32'hF);
        data = 16'h1234; dp = 4'b0010; blink_en = 4'b0010; load = 1'b1; lz_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                if (((k - 1) / 4) % 2 == 0) begin
                    check($sformatf("blink_on_%0d", k), hex, {4'h0, 7'h79, 7'h24, 7'h30, 7'h19});
                    check($sformatf("blink_dp_on_%0d", k), hex_dp, 32'hD);
                end else begin
                    check($sformatf("blink_off_%0d", k), hex, {4'h0, 7'h79, 7'h24, 7'h7F, 7'h19});
                    check($sformatf("blink_dp_off_%0d", k), hex_dp, 32'hF);
                end
            end
        end

        @(posedge clk);
        #2 rst_n = 1'b0;
        data = 16'h89AB; dp = 4'b0000; blink_en = 4'b0000; load = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            int idx;
            @(negedge clk);
            idx = ((k - 1) / 3) % 4;
            check($sformatf("scan_dig_%0d", k), dig, 32'(~(4'b0001 << idx) & 4'hF));
            check($sformatf("scan_dig1_%0d", k), dig1, 32'h0);
            if (k >= 3) begin
                check($sformatf("scan_seg_%0d", k), seg, {24'h0, 1'b1, glyph_ref(data[4*idx +: 4])});
                check($sformatf("scan_seg1_%0d", k), seg1, 32'h83);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_multi_disp.md
Name: seg7_multi_disp

Overview:
- Parametrised multi-digit hexadecimal display driver for DE0-class boards, the successor to the single-digit combinational decoder.
- Captures a packed hex word on a load strobe and drives DIGITS seven-segment positions in two forms: per-digit static outputs (HEX) and a time-multiplexed scan bus (SEG/DIG).
- Adds leading-zero suppression, per-digit decimal points and per-digit blinking.
- Sits between application counters/registers and the board display pins.

Parameters:
- DIGITS, 4, number of display positions; legal range 1..8.
- BLINK_DIV, 25000000, clock cycles per blink half-period (0.5 s at 50 MHz); legal range >= 1.
- SCAN_DIV, 50000, clock cycles each digit is held on the scan bus; legal range >= 1.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- RST  in  1  asynchronous, active-low reset.
- DATA  in  4*DIGITS  packed hex nibbles; nibble i (bits 4i+3..4i) is digit i, and digit 0 is least significant.
- DP  in  DIGITS  decimal-point request per digit, 1 = lit.
- BLINK_EN  in  DIGITS  per-digit blink enable, 1 = blinks.
- LOAD  in  1  capture strobe for DATA/DP/BLINK_EN.
- LZ_EN  in  1  leading-zero suppression enable (live, not captured).
- HEX  out  7*DIGITS  static segments; slice i = digit i in gfedcba order, 0 = segment lit.
- HEX_DP  out  DIGITS  static decimal points, 0 = lit.
- SEG  out  8  scan-bus segments {dp,g,f,e,d,c,b,a}, 0 = lit.
- DIG  out  DIGITS  scan-bus digit select, one-hot, active-low.

Behaviour:
- Reset (RST low, asynchronous):
  - Capture registers, blink counter, blink phase, scan counter and scan index all clear to 0.
  - HEX all 1s, HEX_DP all 1s, SEG 8'hFF, DIG all 1s.
  - Reset applied mid-scan or mid-blink aborts immediately; after release the first scan digit is 0 and blink phase is "on".
- Capture:
  - LOAD high at a rising edge latches DATA, DP and BLINK_EN.
  - LOAD low holds the previous capture.
  - LOAD held high recaptures every cycle.
- Latency:
  - Decode is registered. A capture at edge N appears on HEX/HEX_DP at edge N+1.
  - SEG/DIG register from the decoded HEX, so they reflect the capture at edge N+2 at the earliest (subject to the scan position).
- Glyphs, active-low gfedcba:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=58
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - Blank = 7F.
- Leading-zero suppression (LZ_EN=1):
  - Scanning from digit DIGITS-1 downward, every nibble that is zero blanks until the first nonzero nibble.
  - Digit 0 is never suppressed, so value 0 shows a single "0".
  - DP of a suppressed digit is still honoured.
  - LZ_EN=0 shows all digits.
- Blink:
  - The counter runs 0..BLINK_DIV-1 continuously. At terminal count it wraps to 0 and the phase toggles.
  - Phase 0 = on, phase 1 = off.
  - In the off phase, digits with BLINK_EN=1 blank their segments and DP.
  - BLINK_DIV=1 toggles the phase every cycle.
- Scan:
  - The counter runs 0..SCAN_DIV-1. At terminal count the index advances, wrapping DIGITS-1 to 0.
  - DIG drives bit[index] low. SEG = {HEX_DP[index], HEX slice[index]}.
  - DIGITS=1: index stays 0 and DIG is constantly 0.
- Counter width: $clog2 of each divisor, minimum 1 bit. No other arithmetic.
- Illegal parameter values stop elaboration with an error.

Decomposition:
- Package seg7_pkg holds:
  - SEG_BLANK = 7'h7F;
  - the glyph constant table above;
  - function seg7_glyph_f(nibble) returning 7 bits.
- One natural sub-module, seg7_glyph: a combinational nibble-to-segment decoder built on the function, instantiated DIGITS times by generate.
- Counters, capture, suppression and scan logic stay in the top module.

Test Plan:
- Reset: assert RST low mid-operation -> HEX=all 1s, SEG=FF, DIG=F immediately. Release, LOAD DATA=16'h1234 -> HEX digit3..0 = 79,24,30,19 one edge after LOAD.
- Glyph sweep: DIGITS=4, load 16'h0123, 4567, 89AB, CDEF with LZ_EN=0 -> every slice matches the glyph table; DP=4'b0101 -> HEX_DP=4'b1010.
- Leading zeros: DATA=16'h0040, LZ_EN=1 -> digit3=7F, digit2=7F, digit1=19, digit0=40. DATA=0 -> only digit0=40. Toggling LZ_EN takes effect one edge later.
- Blink: BLINK_DIV=4, BLINK_EN=4'b0010 -> digit1 alternates glyph/7F every 4 cycles, DP included; other digits steady.
- Scan: SCAN_DIV=3, DIGITS=4 -> DIG sequence E,D,B,7 repeating, each held 3 cycles; SEG matches the corresponding static slice. DIGITS=1 build -> DIG stays 0.
- LOAD held high with DATA changing each cycle -> HEX tracks DATA with exactly one-cycle delay.
